// File: rtl/jt12_snd_mixer_if.sv
// Control and data bundle between the sound generators and the stereo mixer.
interface jt12_snd_mixer_if #(
    parameter int CH = 4,
    parameter int W  = 16,
    parameter int GW = 8
);
    logic             cen;
    logic             sample_in;
    logic [CH*W-1:0]  ch_left;
    logic [CH*W-1:0]  ch_right;
    logic [CH*GW-1:0] ch_gain;
    logic             clr_overrun;
    logic [W-1:0]     snd_left;
    logic [W-1:0]     snd_right;
    logic             snd_sample;
    logic             busy;
    logic             overrun;

    modport master (
        output cen, sample_in, ch_left, ch_right, ch_gain, clr_overrun,
        input  snd_left, snd_right, snd_sample, busy, overrun
    );

    modport slave (
        input  cen, sample_in, ch_left, ch_right, ch_gain, clr_overrun,
        output snd_left, snd_right, snd_sample, busy, overrun
    );
endinterface

// File: rtl/jt12_snd_mixer.sv
// Time-multiplexed stereo mixer: one gain multiply-accumulate per enabled cycle,
// arithmetic shift by FRAC and saturation to W bits on output.
module jt12_snd_mixer #(
    parameter int CH   = 4,
    parameter int W    = 16,
    parameter int GW   = 8,
    parameter int FRAC = 4
) (
    input  logic                clk,
    input  logic                rst,
    jt12_snd_mixer_if.slave     bus
);
    localparam int IW = $clog2(CH);
    localparam int PW = W + GW + 1;
    localparam int A  = W + GW + IW + 1;
    localparam logic signed [A-1:0] SAT_MAX = {{(A-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [A-1:0] SAT_MIN = {{(A-W+1){1'b1}}, {(W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_OUT} state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [IW-1:0]          r_idx;
    logic [CH*W-1:0]        r_lq;
    logic [CH*W-1:0]        r_rq;
    logic [CH*GW-1:0]       r_gq;
    logic signed [A-1:0]    r_acc_l;
    logic signed [A-1:0]    r_acc_r;
    logic signed [W-1:0]    r_snd_l;
    logic signed [W-1:0]    r_snd_r;
    logic                   r_sample;
    logic                   r_overrun;

    logic signed [W-1:0]    w_l [CH];
    logic signed [W-1:0]    w_r [CH];
    logic        [GW-1:0]   w_g [CH];
    logic signed [PW-1:0]   w_prod_l;
    logic signed [PW-1:0]   w_prod_r;
    logic signed [A-1:0]    w_shift_l;
    logic signed [A-1:0]    w_shift_r;
    logic signed [W-1:0]    w_sat_l;
    logic signed [W-1:0]    w_sat_r;
    logic                   w_last;

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_unpack
            assign w_l[gi] = r_lq[gi*W +: W];
            assign w_r[gi] = r_rq[gi*W +: W];
            assign w_g[gi] = r_gq[gi*GW +: GW];
        end
    endgenerate

    // Gain is unsigned, so it gets a zero sign bit before the signed multiply.
    assign w_prod_l = w_l[r_idx] * $signed({1'b0, w_g[r_idx]});
    assign w_prod_r = w_r[r_idx] * $signed({1'b0, w_g[r_idx]});
    assign w_last   = (r_idx == IW'(CH-1));

    assign w_shift_l = r_acc_l >>> FRAC;
    assign w_shift_r = r_acc_r >>> FRAC;

    always_comb begin
        w_sat_l = w_shift_l[W-1:0];
        if (w_shift_l > SAT_MAX)      w_sat_l = SAT_MAX[W-1:0];
        else if (w_shift_l < SAT_MIN) w_sat_l = SAT_MIN[W-1:0];
        w_sat_r = w_shift_r[W-1:0];
        if (w_shift_r > SAT_MAX)      w_sat_r = SAT_MAX[W-1:0];
        else if (w_shift_r < SAT_MIN) w_sat_r = SAT_MIN[W-1:0];
    end

    always_comb begin
        w_state_next = r_state;
        if (bus.cen) begin
            case (r_state)
                S_IDLE:  if (bus.sample_in) w_state_next = S_ACC;
                S_ACC:   if (w_last) w_state_next = S_OUT;
                S_OUT:   w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx     <= '0;
            r_lq      <= '0;
            r_rq      <= '0;
            r_gq      <= '0;
            r_acc_l   <= '0;
            r_acc_r   <= '0;
            r_snd_l   <= '0;
            r_snd_r   <= '0;
            r_sample  <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_sample <= 1'b0;
            if (bus.cen) begin
                case (r_state)
                    S_IDLE: if (bus.sample_in) begin
                        r_lq    <= bus.ch_left;
                        r_rq    <= bus.ch_right;
                        r_gq    <= bus.ch_gain;
                        r_acc_l <= '0;
                        r_acc_r <= '0;
                        r_idx   <= '0;
                    end
                    S_ACC: begin
                        r_acc_l <= r_acc_l + {{(A-PW){w_prod_l[PW-1]}}, w_prod_l};
                        r_acc_r <= r_acc_r + {{(A-PW){w_prod_r[PW-1]}}, w_prod_r};
                        if (!w_last) r_idx <= r_idx + 1'b1;
                    end
                    S_OUT: begin
                        r_snd_l  <= w_sat_l;
                        r_snd_r  <= w_sat_r;
                        r_sample <= 1'b1;
                        r_idx    <= '0;
                    end
                    default: r_idx <= '0;
                endcase
            end
            // A strobe while busy sets the flag even if a clear arrives together.
            if (bus.cen && bus.sample_in && r_state != S_IDLE) r_overrun <= 1'b1;
            else if (bus.cen && bus.clr_overrun)                r_overrun <= 1'b0;
        end
    end

    assign bus.snd_left   = r_snd_l;
    assign bus.snd_right  = r_snd_r;
    assign bus.snd_sample = r_sample;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.overrun    = r_overrun;
endmodule

// File: tb/tb_jt12_snd_mixer.sv
// Directed bench for the stereo mixer: latency, gain, saturation, overrun, cen gating, reset abort.
module tb_jt12_snd_mixer;
    localparam int CH = 4, W = 16, GW = 8, FRAC = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    jt12_snd_mixer_if #(.CH(CH), .W(W), .GW(GW)) bus();

    jt12_snd_mixer #(.CH(CH), .W(W), .GW(GW), .FRAC(FRAC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [CH*W-1:0] pack_s(input int a0, input int a1, input int a2, input int a3);
        logic [31:0] v0, v1, v2, v3;
        v0 = a0; v1 = a1; v2 = a2; v3 = a3;
        return {v3[15:0], v2[15:0], v1[15:0], v0[15:0]};
    endfunction

    function automatic logic [CH*GW-1:0] pack_g(input int g0, input int g1, input int g2, input int g3);
        logic [31:0] v0, v1, v2, v3;
        v0 = g0; v1 = g1; v2 = g2; v3 = g3;
        return {v3[7:0], v2[7:0], v1[7:0], v0[7:0]};
    endfunction

    task automatic start_mix(input logic [CH*W-1:0] l, input logic [CH*W-1:0] r, input logic [CH*GW-1:0] g);
        @(negedge clk);
        bus.cen       = 1'b1;
        bus.ch_left   = l;
        bus.ch_right  = r;
        bus.ch_gain   = g;
        bus.sample_in = 1'b1;
    endtask

    // Waits for snd_sample; lat counts clk edges after the latch edge, -1 on timeout.
    task automatic wait_sample(input int div, output int lat, output int busy_n);
        lat = -1;
        busy_n = 0;
        for (int n = 1; n <= 60 && lat < 0; n++) begin
            @(negedge clk);
            if (bus.busy) busy_n++;
            if (bus.snd_sample) lat = n - 1;
            bus.sample_in = 1'b0;
            bus.cen = ((n % div) == 0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.cen = 1'b1; bus.sample_in = 1'b0; bus.clr_overrun = 1'b0;
        bus.ch_left = '0; bus.ch_right = '0; bus.ch_gain = '0;
        repeat (3) @(negedge clk);
        checks += 5;
        if (bus.snd_left !== 16'sd0)   begin errors++; $display("FAIL reset_left got %0d want 0", $signed(bus.snd_left)); end
        if (bus.snd_right !== 16'sd0)  begin errors++; $display("FAIL reset_right got %0d want 0", $signed(bus.snd_right)); end
        if (bus.snd_sample !== 1'b0)   begin errors++; $display("FAIL reset_sample got %b want 0", bus.snd_sample); end
        if (bus.busy !== 1'b0)         begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        if (bus.overrun !== 1'b0)      begin errors++; $display("FAIL reset_overrun got %b want 0", bus.overrun); end
        rst = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_basic();
        int lat, busy_n;
        start_mix(pack_s(1000, 2000, -500, 0), pack_s(100, -200, 300, -400), pack_g(16, 16, 16, 16));
        wait_sample(1, lat, busy_n);
        checks += 4;
        if (lat !== 5)                   begin errors++; $display("FAIL basic_latency got %0d want 5", lat); end
        if (busy_n !== 5)                begin errors++; $display("FAIL basic_busy_cycles got %0d want 5", busy_n); end
        if (bus.snd_left !== 16'sd2500)  begin errors++; $display("FAIL basic_left got %0d want 2500", $signed(bus.snd_left)); end
        if (bus.snd_right !== -16'sd200) begin errors++; $display("FAIL basic_right got %0d want -200", $signed(bus.snd_right)); end
        @(negedge clk);
        checks++;
        if (bus.snd_sample !== 1'b0) begin errors++; $display("FAIL basic_pulse_width got %b want 0", bus.snd_sample); end
        $display("test_basic left=%0d right=%0d lat=%0d", $signed(bus.snd_left), $signed(bus.snd_right), lat);
    endtask

    task automatic test_saturation();
        int lat, busy_n;
        start_mix(pack_s(32767, 32767, 0, 0), '0, pack_g(16, 16, 16, 16));
        wait_sample(1, lat, busy_n);
        checks++;
        if (lat !== 5 || bus.snd_left !== 16'sd32767) begin
            errors++; $display("FAIL sat_pos got %0d (lat %0d) want 32767", $signed(bus.snd_left), lat);
        end
        $display("test_saturation pos left=%0d", $signed(bus.snd_left));
        start_mix(pack_s(-32768, -32768, 0, 0), '0, pack_g(16, 16, 16, 16));
        wait_sample(1, lat, busy_n);
        checks++;
        if (lat !== 5 || bus.snd_left !== -16'sd32768) begin
            errors++; $display("FAIL sat_neg got %0d (lat %0d) want -32768", $signed(bus.snd_left), lat);
        end
        $display("test_saturation neg left=%0d", $signed(bus.snd_left));
    endtask

    task automatic test_gain_floor();
        int lat, busy_n;
        start_mix(pack_s(-3, 1000, 1000, 1000), pack_s(3, 500, 500, 500), pack_g(8, 0, 0, 0));
        wait_sample(1, lat, busy_n);
        checks += 2;
        if (bus.snd_left !== -16'sd2) begin errors++; $display("FAIL floor_left got %0d want -2", $signed(bus.snd_left)); end
        if (bus.snd_right !== 16'sd1) begin errors++; $display("FAIL floor_right got %0d want 1", $signed(bus.snd_right)); end
        $display("test_gain_floor left=%0d right=%0d", $signed(bus.snd_left), $signed(bus.snd_right));
    endtask

    task automatic test_overrun();
        int pulses;
        logic signed [W-1:0] left_at_pulse;
        int lat, busy_n;
        pulses = 0;
        left_at_pulse = '0;
        start_mix(pack_s(1000, 2000, -500, 0), pack_s(100, -200, 300, -400), pack_g(16, 16, 16, 16));
        @(negedge clk);
        bus.sample_in = 1'b0;
        @(negedge clk);
        bus.sample_in = 1'b1;
        bus.ch_left = pack_s(7, 7, 7, 7);
        bus.ch_gain = pack_g(255, 255, 255, 255);
        @(negedge clk);
        bus.sample_in = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.snd_sample) begin pulses++; left_at_pulse = bus.snd_left; end
        end
        checks += 3;
        if (pulses !== 1)                  begin errors++; $display("FAIL ovr_pulses got %0d want 1", pulses); end
        if (left_at_pulse !== 16'sd2500)   begin errors++; $display("FAIL ovr_left got %0d want 2500", left_at_pulse); end
        if (bus.overrun !== 1'b1)          begin errors++; $display("FAIL ovr_flag got %b want 1", bus.overrun); end
        bus.clr_overrun = 1'b1;
        @(negedge clk);
        bus.clr_overrun = 1'b0;
        checks++;
        if (bus.overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b want 0", bus.overrun); end
        start_mix(pack_s(1, 1, 1, 1), '0, pack_g(16, 16, 16, 16));
        @(negedge clk);
        bus.sample_in = 1'b1;
        bus.clr_overrun = 1'b1;
        @(negedge clk);
        bus.sample_in = 1'b0;
        bus.clr_overrun = 1'b0;
        checks++;
        if (bus.overrun !== 1'b1) begin errors++; $display("FAIL ovr_set_wins got %b want 1", bus.overrun); end
        wait_sample(1, lat, busy_n);
        bus.clr_overrun = 1'b1;
        @(negedge clk);
        bus.clr_overrun = 1'b0;
        $display("test_overrun pulses=%0d left=%0d", pulses, left_at_pulse);
    endtask

    task automatic test_cen_gating();
        int lat, busy_n;
        start_mix(pack_s(1000, 2000, -500, 0), pack_s(100, -200, 300, -400), pack_g(16, 16, 16, 16));
        wait_sample(3, lat, busy_n);
        checks += 2;
        if (lat !== 15)                 begin errors++; $display("FAIL cen_latency got %0d want 15", lat); end
        if (bus.snd_left !== 16'sd2500) begin errors++; $display("FAIL cen_left got %0d want 2500", $signed(bus.snd_left)); end
        @(negedge clk);
        checks++;
        if (bus.snd_sample !== 1'b0) begin errors++; $display("FAIL cen_pulse_width got %b want 0", bus.snd_sample); end
        bus.cen = 1'b1;
        $display("test_cen_gating lat=%0d left=%0d", lat, $signed(bus.snd_left));
    endtask

    task automatic test_reset_abort();
        int pulses, lat, busy_n;
        pulses = 0;
        start_mix(pack_s(1000, 2000, -500, 0), pack_s(100, -200, 300, -400), pack_g(16, 16, 16, 16));
        @(negedge clk);
        bus.sample_in = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks += 3;
        if (bus.busy !== 1'b0)         begin errors++; $display("FAIL abort_busy got %b want 0", bus.busy); end
        if (bus.snd_left !== 16'sd0)   begin errors++; $display("FAIL abort_left got %0d want 0", $signed(bus.snd_left)); end
        if (bus.snd_right !== 16'sd0)  begin errors++; $display("FAIL abort_right got %0d want 0", $signed(bus.snd_right)); end
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (bus.snd_sample) pulses++;
        end
        checks++;
        if (pulses !== 0) begin errors++; $display("FAIL abort_no_sample got %0d want 0", pulses); end
        start_mix(pack_s(-100, 50, 0, 0), pack_s(7, 0, 0, 0), pack_g(32, 16, 0, 0));
        wait_sample(1, lat, busy_n);
        checks += 2;
        if (bus.snd_left !== -16'sd150) begin errors++; $display("FAIL fresh_left got %0d want -150", $signed(bus.snd_left)); end
        if (bus.snd_right !== 16'sd14)  begin errors++; $display("FAIL fresh_right got %0d want 14", $signed(bus.snd_right)); end
        $display("test_reset_abort fresh left=%0d right=%0d", $signed(bus.snd_left), $signed(bus.snd_right));
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_gain_floor();
        test_overrun();
        test_cen_gating();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
